// File: rtl/tt_uart5_tx_if.sv
// Tile pin bundle for the 5N1 serial transmitter: clock, reset, start and
// payload arrive on io_in; line, status and debug state leave on io_out.
interface tt_uart5_tx_if;
  // Launch protocol: a 0->1 edge on io_in[2] sampled while idle starts one
  // frame carrying io_in[7:3]; io_out[1] (busy) stays high for the whole
  // frame and io_out[2] (done) pulses for one cycle after it ends. Edges
  // seen while busy are dropped, never queued.
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tt_uart5_tx.sv
// 5N1 asynchronous serial transmitter tile, LSB first, idle-high line.
// Every io_out bit comes straight from a flop.
module tt_uart5_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  tt_uart5_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] data;

  assign clk   = bus.io_in[0];
  assign rst_n = bus.io_in[1];
  assign start = bus.io_in[2];
  assign data  = bus.io_in[7:3];

  state_t          state;
  logic            tx;
  logic            busy;
  logic            done;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   cnt;
  logic            start_prev;
  logic [4:0]      shift;

  assign bus.io_out = {bit_idx, state, done, busy, tx};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_idx    <= 3'd0;
      cnt        <= '0;
      start_prev <= 1'b0;
      shift      <= 5'd0;
    end else begin
      start_prev <= start;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start && !start_prev) begin
            shift <= data;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == TERM) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            tx      <= shift[0];
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == TERM) begin
            cnt <= '0;
            if (bit_idx == 3'd4) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_idx <= 3'd0;
            end else begin
              // shift[1] becomes the new shift[0] on this same edge
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == TERM) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_uart5_tx.sv
// Bench for tt_uart5_tx: two instances (4 and 1 clocks per bit), payloads
// queued at launch and checked cycle by cycle against a frame model.
module tb_tt_uart5_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst1, start4, start1;
  logic [4:0] data4, data1;

  tt_uart5_tx_if if4 ();
  tt_uart5_tx_if if1 ();

  assign if4.io_in = {data4, start4, rst4, clk};
  assign if1.io_in = {data1, start1, rst1, clk};

  tt_uart5_tx #(.CLKS_PER_BIT(4)) dut4 (.bus(if4));
  tt_uart5_tx #(.CLKS_PER_BIT(1)) dut1 (.bus(if1));

  logic [7:0] obs [2];
  logic       rstv [2];
  assign obs[0]  = if4.io_out;
  assign obs[1]  = if1.io_out;
  assign rstv[0] = rst4;
  assign rstv[1] = rst1;

  logic [4:0] exp_q4[$];
  logic [4:0] exp_q1[$];

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output bits: {bit_idx[2:0], state[1:0], done, busy, tx}
  task automatic run_monitor(input int d, input int cpb);
    logic [7:0] o;
    logic [7:0] e;
    logic [4:0] p;
    logic       prev_rst;
    logic       txb;
    logic [1:0] st;
    logic [2:0] bidx;
    int         ph;
    bit         aborted;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      o = obs[d];
      if (!o[1]) begin
        check("idle_out", 32'(o), 32'h01);
        prev_rst = rstv[d];
      end else begin
        p = 5'd0;
        if (d == 0) begin
          check("frame_expected", 32'(exp_q4.size() > 0), 32'd1);
          if (exp_q4.size() > 0) p = exp_q4.pop_front();
        end else begin
          check("frame_expected", 32'(exp_q1.size() > 0), 32'd1);
          if (exp_q1.size() > 0) p = exp_q1.pop_front();
        end
        aborted = 1'b0;
        for (int k = 0; k < 7 * cpb; k++) begin
          if (k > 0) begin
            @(negedge clk);
            o = obs[d];
            if (!prev_rst) begin
              aborted = 1'b1;
              check("after_reset", 32'(o), 32'h01);
              prev_rst = rstv[d];
              break;
            end
          end
          prev_rst = rstv[d];
          ph = k / cpb;
          if (ph == 0) begin
            txb = 1'b0; st = 2'd1; bidx = 3'd0;
          end else if (ph <= 5) begin
            txb = p[ph-1]; st = 2'd2; bidx = 3'(ph - 1);
          end else begin
            txb = 1'b1; st = 2'd3; bidx = 3'd0;
          end
          e = {bidx, st, 1'b0, 1'b1, txb};
          check("frame_out", 32'(o), 32'(e));
        end
        if (!aborted) begin
          @(negedge clk);
          o = obs[d];
          check("done_cycle", 32'(o), 32'h05);
          prev_rst = rstv[d];
        end
      end
    end
  endtask

  task automatic launch(input int d, input logic [4:0] v);
    @(posedge clk); #1;
    if (d == 0) start4 = 1'b0; else start1 = 1'b0;
    @(posedge clk); #1;
    if (d == 0) begin
      data4 = v; start4 = 1'b1; exp_q4.push_back(v);
    end else begin
      data1 = v; start1 = 1'b1; exp_q1.push_back(v);
    end
  endtask

  task automatic drop_start(input int d);
    @(posedge clk); #1;
    if (d == 0) start4 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs[d][2] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    logic [4:0] v;
    n_checks = 0;
    n_fail   = 0;
    rst4 = 1'b0; rst1 = 1'b0;
    start4 = 1'b0; start1 = 1'b0;
    data4 = 5'd0; data1 = 5'd0;

    // reset, then idle line
    repeat (2) @(posedge clk);
    #1;
    fork
      run_monitor(0, 4);
      run_monitor(1, 1);
    join_none
    rst4 = 1'b1; rst1 = 1'b1;
    repeat (20) @(posedge clk);

    // single frame with start held ~100 cycles and payload changed mid-frame
    launch(0, 5'b10110);
    repeat (10) @(posedge clk);
    #1 data4 = 5'b01001;
    repeat (89) @(posedge clk);
    #1 start4 = 1'b0;
    repeat (5) @(posedge clk);

    // second rising edge during busy is dropped
    launch(0, 5'b10110);
    repeat (6) @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 start4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 start4 = 1'b0;
    wait_done(0, 100);
    repeat (3) @(posedge clk);

    // back-to-back: relaunch on the done cycle
    launch(0, 5'b01101);
    drop_start(0);
    wait_done(0, 100);
    start4 = 1'b1;
    data4  = 5'b11111;
    exp_q4.push_back(5'b11111);
    drop_start(0);
    wait_done(0, 100);
    repeat (3) @(posedge clk);

    // reset during DATA bit 2, then a fresh frame
    launch(0, 5'b10110);
    drop_start(0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (obs[0][4:3] == 2'd2 && obs[0][7:5] == 3'd2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("bit2_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 rst4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b1;
    repeat (3) @(posedge clk);
    launch(0, 5'b00111);
    drop_start(0);
    wait_done(0, 100);

    // one clock per bit
    launch(1, 5'b00001);
    drop_start(1);
    wait_done(1, 50);
    launch(1, 5'b10101);
    drop_start(1);
    wait_done(1, 50);

    // random payloads on both instances
    for (int i = 0; i < 4; i++) begin
      v = 5'($urandom_range(0, 31));
      launch(0, v);
      drop_start(0);
      wait_done(0, 100);
      v = 5'($urandom_range(0, 31));
      launch(1, v);
      drop_start(1);
      wait_done(1, 50);
    end

    repeat (10) @(posedge clk);
    check("q4_drained", 32'(exp_q4.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
